// File: rtl/store_buf_pkg.sv
// Shared definitions for the store buffer.
//   sb_entry_t       : one buffered store (word address, byte enables, lane-aligned data)
//   drain_state_t    : drain FSM states
//   SB_DEFAULT_DEPTH : default number of buffered entries
package store_buf_pkg;

    localparam int SB_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
    } sb_entry_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Circular storage for the store buffer.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   push, push_entry  : write an entry at the tail (ignored when full)
//   pop               : retire the head entry (ignored when empty)
//   head              : current head entry
//   full, empty       : occupancy flags
//   count             : number of valid entries, 0..DEPTH
//   entries, valid    : whole storage array and per-slot valid bits for address compares
module sb_fifo
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  sb_entry_t                push_entry,
    input  logic                     pop,
    output sb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output sb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] valid_q;
    sb_entry_t        mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Guarding here means push and pop can never touch the same slot in one cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr          <= wr_ptr + PW'(1);
                valid_q[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr          <= rd_ptr + PW'(1);
                valid_q[rd_ptr] <= 1'b0;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Payload storage carries no reset; validity is tracked by valid_q/count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head    = mem[rd_ptr];
    assign entries = mem;
    assign valid   = valid_q;
    assign count   = count_q;
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/store_buffer.sv
// Store buffer between execute stage and data memory.
// Accepts stores, aligns data to byte lanes, queues them in program order and
// drains them one at a time with a req/ack handshake. Flags loads that hit a
// word with a pending store.
// Ports:
//   clk, reset                 : clock and synchronous active-high reset
//   st_valid/st_ready          : store handshake from execute
//   st_addr, st_we, st_data    : store address, shifted byte enables, unaligned data
//   mem_req/mem_ack            : write handshake to data memory
//   mem_addr, mem_we, mem_wdata: head entry (zero while idle)
//   ld_addr, ld_hazard         : load word address and overlap flag
//   empty                      : no pending entries
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = SB_DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [3:0]  st_we,
    input  logic [31:0] st_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        empty
);

    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_t     state;
    drain_state_t     state_next;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    sb_entry_t        push_entry;
    sb_entry_t        head;
    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             unused_bits;

    assign st_ready = !reset && !fifo_full;
    // A store with no byte enables is accepted but never queued.
    assign push     = st_valid && st_ready && (st_we != 4'b0000);
    assign pop      = (state == DRAIN_REQ) && mem_ack;
    assign empty    = fifo_empty;

    // Word-align the address and move the data into its byte lanes.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = {st_addr[31:2], 2'b00};
        push_entry.we   = st_we;
        push_entry.data = st_data << {st_addr[1:0], 3'b000};
    end

    sb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count),
        .entries   (entries),
        .valid     (valid)
    );

    // Occupancy after this edge; decides whether the drain has work next cycle.
    assign count_next = count + CW'(push) - CW'(pop);

    // Drain state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain next-state and memory-side outputs; the head is held until acked.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_we     = '0;
        mem_wdata  = '0;
        case (state)
            DRAIN_IDLE: begin
                if (count_next != '0) begin
                    state_next = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                mem_req   = 1'b1;
                mem_addr  = head.addr;
                mem_we    = head.we;
                mem_wdata = head.data;
                if (count_next == '0) begin
                    state_next = DRAIN_IDLE;
                end
            end
            default: state_next = DRAIN_IDLE;
        endcase
    end

    // Load overlap: any valid entry, including the head under issue, on the same word.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr[31:2] == ld_addr[31:2])) begin
                ld_hazard = 1'b1;
            end
        end
    end

    // Fields of the array not needed for the word compare.
    always_comb begin
        unused_bits = ^ld_addr[1:0];
        for (int i = 0; i < DEPTH; i++) begin
            unused_bits = unused_bits ^ (^{entries[i].addr[1:0], entries[i].we, entries[i].data});
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port st_valid  input  1  store request from execute stage.
REQ-005 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-006 SHALL have port st_addr  input  32  store byte address.
REQ-007 SHALL have port st_we  input  4  byte enables from store-type decoder, already shifted by st_addr[1:0].
REQ-008 SHALL have port st_data  input  32  unaligned rs2 value.
REQ-009 SHALL have port mem_req  output  1  write request to data memory.
REQ-010 SHALL have port mem_ack  input  1  data memory accepts current request.
REQ-011 SHALL have port mem_addr  output  32  word-aligned write address.
REQ-012 SHALL have port mem_we  output  4  byte enables of head entry.
REQ-013 SHALL have port mem_wdata  output  32  lane-aligned write data.
REQ-014 SHALL have port ld_addr  input  32  address of load in memory stage.
REQ-015 SHALL have port ld_hazard  output  1  pending store overlaps load word.
REQ-016 SHALL have port empty  output  1  no pending entries.

Function
REQ-017 Push SHALL occur on st_valid && st_ready && st_we!=0; st_valid with st_we==0 SHALL be accepted and discarded.
REQ-018 Entry SHALL store {st_addr[31:2],2'b00}, st_we, st_data << (8*st_addr[1:0]) truncated to 32 bits.
REQ-019 st_ready SHALL be 1 iff count<DEPTH and reset is low; a same-cycle pop SHALL NOT admit a push when full.
REQ-020 Drain FSM SHALL have states IDLE (mem_req=0) and REQ (mem_req=1, mem_* = head entry).
REQ-021 IDLE->REQ SHALL occur at the edge where count!=0 (includes entry pushed that edge); push at edge N gives mem_req=1 in cycle N+1.
REQ-022 In REQ, mem_addr/mem_we/mem_wdata SHALL stay stable until mem_req&&mem_ack; that edge pops head.
REQ-023 After pop, FSM SHALL stay REQ with next head if count (after pop and any push) !=0, else go IDLE; back-to-back acks SHALL drain one entry per cycle.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-025 ld_hazard SHALL be combinational: 1 iff any valid entry (including head under issue) has addr[31:2]==ld_addr[31:2]; same-cycle incoming store SHALL NOT count.
REQ-026 In IDLE, mem_addr, mem_we, mem_wdata SHALL be 0.
REQ-027 empty SHALL equal (count==0).
REQ-028 Stores SHALL drain in program order; no merging or reordering.

Reset
REQ-029 On reset edge: pointers=0, count=0, FSM=IDLE, mem_req=0, ld_hazard=0, empty=1, st_ready=0 while reset high.
REQ-030 Reset during REQ SHALL discard all entries including the unacknowledged head; mem_req SHALL be 0 the next cycle regardless of mem_ack.
REQ-031 Entry storage contents need not be reset; only valid-tracking state is reset.

Structure
REQ-032 Shared package store_buf_pkg SHALL hold entry struct typedef (addr, we, data), drain-state enum, and default DEPTH constant.
REQ-033 Storage SHALL be a sub-module sb_fifo (push/pop/full/empty, entry array visible for hazard compare); alignment and FSM live in store_buffer.

Verification
REQ-034 SB: st_addr=0x1003, st_we=4'b1000, st_data=0x000000AB -> cycle+1 mem_req=1, mem_addr=0x1000, mem_we=4'b1000, mem_wdata=0xAB000000.
REQ-035 Fill: 5 SW pushes with mem_ack=0 -> st_ready=0 after 4th, 5th held; one ack -> 5th accepted next cycle, order preserved.
REQ-036 Ack stall: hold mem_ack=0 for 3 cycles on SH addr 0x2002 data 0x1234 -> mem_wdata=0x12340000, mem_we=4'b1100 stable all 3 cycles.
REQ-037 Hazard: pending SW at 0x3000, ld_addr=0x3002 -> ld_hazard=1; ld_addr=0x3004 -> 0; after ack -> 0.
REQ-038 Reset with 3 entries and mem_req=1, mem_ack=1 same cycle -> next cycle mem_req=0, empty=1, no further writes.
REQ-039 Simultaneous push/pop at count=2 with mem_ack=1 every cycle -> count stays 2, one write per cycle, addresses in push order.
